inst_loader: RTL and testbench

- Host-side instruction loader directly upstream of the NPU controller's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian instruction words and writes them to instruction memory at consecutive addresses from 0.
- Holds the controller in reset while loading and releases it (core_reset low) once the program is complete.

---
 rtl/inst_loader_pkg.sv | 21 ++
 rtl/inst_loader_byte_word_assembler.sv | 49 ++++
 rtl/inst_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: definitions shared by the instruction loader files.
//   - loader_state_t : loader FSM states (IDLE, HDR, DATA, CHK, RUN, ERR)
//   - INST_WIDTH, INST_MEM_DEPTH, INST_MEM_SIZE, LEN_BYTES : default geometry
// CHK is only reachable when LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int INST_MEM_DEPTH = 10;
  localparam int INST_MEM_SIZE  = 1 << INST_MEM_DEPTH;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/inst_loader_byte_word_assembler.sv
// byte_word_assembler: packs a byte stream, LSB first, into WORD_W-bit words.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous flush of partial word, counter and strobe
//   byte_valid   : a byte is consumed this cycle
//   byte_data    : the byte
//   word         : assembled word (valid while word_valid is high)
//   word_valid   : one-cycle strobe, the cycle after the completing byte
//   word_last    : combinational, the byte consumed this cycle completes a word
module byte_word_assembler #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  localparam int NBYTES = WORD_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign word_last = byte_valid && (byte_cnt == CNT_W'(NBYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (byte_valid) begin
        // New bytes enter at the top so the first byte ends up in bits [7:0].
        word     <= (word >> 8) | (WORD_W'(byte_data) << (WORD_W - 8));
        byte_cnt <= word_last ? '0 : byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a program from a byte stream into NPU instruction memory.
// Stream format: LEN_BYTES little-endian word count, then len little-endian
// words, then (LOADER_CHECKSUM_EN only) one XOR checksum byte over all
// header and data bytes. The controller is held in core_reset until done.
// Optional feature macro: LOADER_CHECKSUM_EN.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   s_data/s_valid/s_ready : byte stream handshake (s_ready depends on state only)
//   load_req            : one-cycle pulse, abort and restart loading
//   inst_write_addr/data/enable : instruction memory write port
//   core_reset          : controller held in reset while high
//   done                : program loaded, controller released
//   error               : sticky load error (oversize length / bad checksum)
module inst_loader #(
  parameter int INST_WIDTH     = inst_loader_pkg::INST_WIDTH,
  parameter int INST_MEM_DEPTH = inst_loader_pkg::INST_MEM_DEPTH,
  parameter int LEN_BYTES      = inst_loader_pkg::LEN_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      load_req,
  output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
  output logic [INST_WIDTH-1:0]     inst_write_data,
  output logic                      inst_write_enable,
  output logic                      core_reset,
  output logic                      done,
  output logic                      error
);

  import inst_loader_pkg::*;

  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int HCNT_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  // One bit wider than the address so a full-memory program does not wrap.
  localparam int CNT_W  = INST_MEM_DEPTH + 1;

  loader_state_t     state;
  loader_state_t     nxt;
  logic [HCNT_W-1:0] hdr_cnt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  hdr_len;
  logic [CNT_W-1:0]  word_cnt;
  logic              accept;
  logic              hdr_last;
  logic              too_big;
  logic              asm_valid;
  logic              word_last;
  logic              data_done;

  // load_req wins over a byte offered in the same cycle.
  assign accept    = s_valid && s_ready && !load_req;
  assign hdr_last  = accept && (state == HDR) && (hdr_cnt == HCNT_W'(LEN_BYTES - 1));
  // len is cleared before each header, so OR-ing the byte in place is enough.
  assign hdr_len   = len | (LEN_W'(s_data) << (8 * hdr_cnt));
  assign too_big   = (33'(hdr_len) > (33'd1 << INST_MEM_DEPTH));
  assign asm_valid = accept && (state == DATA);
  assign data_done = word_last && ((word_cnt + 1'b1) == CNT_W'(len));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (load_req) begin
      csum <= '0;
    end else if (accept && ((state == HDR) || (state == DATA))) begin
      csum <= csum ^ s_data;
    end
  end
`endif

  byte_word_assembler #(
    .WORD_W(INST_WIDTH)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_req),
    .byte_valid(asm_valid),
    .byte_data (s_data),
    .word      (inst_write_data),
    .word_valid(inst_write_enable),
    .word_last (word_last)
  );

  always_comb begin
    nxt = state;
    if (load_req) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: nxt = HDR;
        HDR: begin
          if (hdr_last) begin
            if (hdr_len == '0)  nxt = RUN;
            else if (too_big)   nxt = ERR;
            else                nxt = DATA;
          end
        end
        DATA: begin
          if (data_done) begin
`ifdef LOADER_CHECKSUM_EN
            nxt = CHK;
`else
            nxt = RUN;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) nxt = (s_data == csum) ? RUN : ERR;
        end
`endif
        default: nxt = state;
      endcase
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      s_ready         <= 1'b0;
      core_reset      <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
      hdr_cnt         <= '0;
      len             <= '0;
      word_cnt        <= '0;
      inst_write_addr <= '0;
    end else begin
      state      <= nxt;
      s_ready    <= (nxt == HDR) || (nxt == DATA) || (nxt == CHK);
      core_reset <= (nxt != RUN);
      done       <= (nxt == RUN);
      error      <= (nxt == ERR);
      if (load_req) begin
        hdr_cnt  <= '0;
        len      <= '0;
        word_cnt <= '0;
      end else begin
        if (accept && (state == HDR)) begin
          len     <= hdr_len;
          hdr_cnt <= hdr_cnt + 1'b1;
        end
        // Address is captured with the completing byte, so it lines up with
        // the assembler's strobe one cycle later and holds afterwards.
        if (word_last) begin
          inst_write_addr <= word_cnt[INST_MEM_DEPTH-1:0];
          word_cnt        <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  localparam int MEM_SIZE = 1024;

  logic        clk;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        load_req;
  logic [9:0]  inst_write_addr;
  logic [31:0] inst_write_data;
  logic        inst_write_enable;
  logic        core_reset;
  logic        done;
  logic        error;

  inst_loader dut (
    .clk              (clk),
    .reset            (reset),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .load_req         (load_req),
    .inst_write_addr  (inst_write_addr),
    .inst_write_data  (inst_write_data),
    .inst_write_enable(inst_write_enable),
    .core_reset       (core_reset),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t obs_q[$];

  always @(negedge clk) begin
    if (inst_write_enable === 1'b1)
      obs_q.push_back('{addr: inst_write_addr, data: inst_write_data, cyc: cyc});
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offers one byte (starting at a negedge), optionally after idle gaps, and
  // returns the cycle number seen at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc);
    int budget;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    budget  = 0;
    while (s_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (s_ready !== 1'b1) begin
      check("ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic pulse_load_req(input string tag);
    s_valid  = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check({tag, "_error"},      64'(error),      64'd0);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_done"},       64'(done),       64'd0);
    obs_q.delete();
  endtask

  // Reference model: a program is a header carrying len, then len words of
  // 4 little-endian bytes, written to addresses 0..len-1; len above the
  // memory size is an error, len 0 runs at once.
  // mode 0: random data, 1: bytes 11 22 33 ..., 2: bytes AA BB CC DD ...
  task automatic run_load(input int len_field, input int mode, input bit gaps,
                          input bit bad_csum, input string tag);
    int          nw;
    int          acc;
    int          idx;
    bit          ok;
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] w;
    logic [31:0] wexp[$];
    int          wcyc[$];
    nw = (len_field > 0 && len_field <= MEM_SIZE) ? len_field : 0;
    ok = (len_field <= MEM_SIZE);
    obs_q.delete();
    x = 8'h00;
    for (int i = 0; i < 2; i++) begin
      b = 8'(len_field >> (8 * i));
      send_byte(b, gaps, acc);
      x = x ^ b;
    end
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * i + k;
        if (mode == 0)      b = 8'($urandom);
        else if (mode == 1) b = 8'(8'h11 * (idx + 1));
        else                b = 8'(8'hAA + 8'h11 * idx);
        send_byte(b, gaps, acc);
        x = x ^ b;
        w = w | (32'(b) << (8 * k));
      end
      wexp.push_back(w);
      wcyc.push_back(acc);
    end
`ifdef LOADER_CHECKSUM_EN
    if (nw > 0) begin
      send_byte(bad_csum ? (x ^ 8'h03) : x, gaps, acc);
      if (bad_csum) ok = 1'b0;
    end
`endif
    s_valid = 1'b0;
    check({tag, "_done"},       64'(done),       64'(ok));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(!ok));
    check({tag, "_error"},      64'(error),      64'(!ok));
    check({tag, "_s_ready"},    64'(s_ready),    64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < obs_q.size(); i++) begin
      check({tag, "_addr"}, 64'(obs_q[i].addr), 64'(i));
      check({tag, "_data"}, 64'(obs_q[i].data), 64'(wexp[i]));
      check({tag, "_lat"},  64'(obs_q[i].cyc),  64'(wcyc[i]));
    end
    if (nw > 0)
      check({tag, "_addr_hold"}, 64'(inst_write_addr), 64'(nw - 1));
    check({tag, "_still_done"}, 64'(done), 64'(ok));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready",    64'(s_ready),           64'd0);
    check("rst_addr",       64'(inst_write_addr),   64'd0);
    check("rst_wdata",      64'(inst_write_data),   64'd0);
    check("rst_we",         64'(inst_write_enable), 64'd0);
    check("rst_core_reset", 64'(core_reset),        64'd1);
    check("rst_done",       64'(done),              64'd0);
    check("rst_error",      64'(error),             64'd0);
    reset = 1'b0;

    // Two words at full rate.
    run_load(2, 1, 1'b0, 1'b0, "t1");
    if (obs_q.size() >= 2) begin
      check("t1_w0_const", 64'(obs_q[0].data), 64'h44332211);
      check("t1_w1_const", 64'(obs_q[1].data), 64'h88776655);
    end

    // Empty program.
    pulse_load_req("lr_t2");
    run_load(0, 0, 1'b0, 1'b0, "t2");

    // Oversize header 01 04 (1025 words).
    pulse_load_req("lr_t3");
    run_load(1025, 0, 1'b0, 1'b0, "t3");
    pulse_load_req("t3_clr");

    // Three words with random valid gaps.
    run_load(3, 0, 1'b1, 1'b0, "t4");

    // Abort mid-word; the byte offered with load_req must not be taken.
    pulse_load_req("lr_ab");
    send_byte(8'h02, 1'b0, acc);
    send_byte(8'h00, 1'b0, acc);
    for (int k = 0; k < 4; k++) send_byte(8'(8'h10 + k), 1'b0, acc);
    send_byte(8'hE1, 1'b0, acc);
    send_byte(8'hE2, 1'b0, acc);
    s_data   = 8'hE3;
    s_valid  = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    s_valid  = 1'b0;
    check("ab_core_reset", 64'(core_reset), 64'd1);
    check("ab_s_ready",    64'(s_ready),    64'd0);
    repeat (3) @(negedge clk);
    check("ab_nwrites", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) check("ab_w0", 64'(obs_q[0].data), 64'h13121110);
    run_load(1, 0, 1'b0, 1'b0, "ab_restart");

    // Checksum pass and fail (plain one-word loads when the feature is off).
    pulse_load_req("lr_ck1");
    run_load(1, 2, 1'b0, 1'b0, "ck_ok");
    if (obs_q.size() > 0) check("ck_ok_word", 64'(obs_q[0].data), 64'hDDCCBBAA);
    pulse_load_req("lr_ck2");
    run_load(1, 2, 1'b0, 1'b1, "ck_bad");

    // Asynchronous reset in the middle of a word.
    pulse_load_req("lr_ar");
    send_byte(8'h02, 1'b0, acc);
    send_byte(8'h00, 1'b0, acc);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, acc);
    s_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("ar_s_ready",    64'(s_ready),           64'd0);
    check("ar_core_reset", 64'(core_reset),        64'd1);
    check("ar_we",         64'(inst_write_enable), 64'd0);
    check("ar_wdata",      64'(inst_write_data),   64'd0);
    check("ar_addr",       64'(inst_write_addr),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_load(1, 0, 1'b1, 1'b0, "ar_restart");

    // Randomized programs.
    for (int it = 0; it < 12; it++) begin
      int  l;
      bit  g;
      bit  bad;
      if ($urandom_range(0, 7) == 0) l = 1025 + $urandom_range(0, 100);
      else                           l = $urandom_range(0, 6);
      g   = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 3) == 0);
      pulse_load_req("lr_rnd");
      run_load(l, 0, g, bad, "rnd");
    end

    // Largest program: last write lands at the top address.
    pulse_load_req("lr_max");
    run_load(MEM_SIZE, 0, 1'b0, 1'b0, "max");
    if (obs_q.size() > 0)
      check("max_last_addr", 64'(obs_q[obs_q.size()-1].addr), 64'(MEM_SIZE - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
